hog_pixel_ingress: RTL
======================

HOG_PIXEL_INGRESS -- requirements
Module: hog_pixel_ingress

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter IMAGE_WIDTH, default 640, pixels per row; must be a multiple of NUM_LANES.
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 480, rows per frame.
REQ-004 SHALL have parameter NUM_LANES, default 4, pixels per input beat; legal range 1..16.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have port in_valid  input  1  in_pixels carries a valid beat.
REQ-008 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-009 SHALL have port in_pixels  input  DATA_WIDTH*NUM_LANES  packed pixels; lane k = bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is leftmost pixel.
REQ-010 SHALL have port out_valid  output  1  out_pixel valid.
REQ-011 SHALL have port out_ready  input  1  downstream (binning stage) accepts pixel.
REQ-012 SHALL have port out_pixel  output  DATA_WIDTH  serialized pixel.
REQ-013 SHALL have ports out_sof, out_eol, out_eof  output  1 each  first-of-frame, last-of-row, last-of-frame tags, qualified by out_valid.
REQ-014 SHALL have ports col  output  $clog2(IMAGE_WIDTH), row  output  $clog2(IMAGE_HEIGHT)  coordinates of out_pixel.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last pixel of a frame is handed off.

Function
REQ-016 SHALL hold one beat in a lane register with lane index and a two-state FSM: EMPTY (no beat held) and DRAIN (beat held, emitting lanes).
REQ-017 EMPTY: in_ready=1; on in_valid, capture beat, lane index=0, go DRAIN.
REQ-018 DRAIN: out_valid=1, out_pixel=held lane[index]; on out handshake index increments.
REQ-019 On handshake of lane NUM_LANES-1: if in_valid, capture new beat and stay DRAIN (index=0); else go EMPTY.
REQ-020 in_ready SHALL be 1 in EMPTY, or in DRAIN when index=NUM_LANES-1 and out_ready=1 (combinational from out_ready); else 0.
REQ-021 Latency: beat accepted in cycle N -> lane 0 on out_pixel in cycle N+1; sustained throughput 1 pixel/cycle, no bubbles between beats.
REQ-022 While out_valid=1 and out_ready=0, out_pixel, tags, col, row SHALL stay stable.
REQ-023 col increments on each out handshake, wraps IMAGE_WIDTH-1 -> 0 and increments row; row wraps IMAGE_HEIGHT-1 -> 0.
REQ-024 out_sof = (col==0 && row==0); out_eol = (col==IMAGE_WIDTH-1); out_eof = out_eol && (row==IMAGE_HEIGHT-1).
REQ-025 frame_done SHALL pulse high for exactly one cycle, the cycle after the handshake with out_eof=1.
REQ-026 NUM_LANES=1: behaves as a one-entry pipeline register with identical tagging and handshake rules.
REQ-027 in_valid with in_ready=0 SHALL not capture; upstream must hold the beat.

Reset
REQ-028 On rst: FSM=EMPTY, lane index=0, col=0, row=0, out_valid=0, frame_done=0, held data cleared to 0.
REQ-029 rst mid-frame SHALL discard the held beat; next accepted beat starts a new frame at col=0,row=0.
REQ-030 in_ready SHALL be 0 during the rst cycle and 1 the cycle after.

Configuration
REQ-031 Macro HOG_INGRESS_STATS_EN defined: adds outputs frame_count (16 bits, increments on frame_done, wraps) and stall_count (16 bits, increments each cycle out_valid=1 and out_ready=0, saturates at 0xFFFF, cleared on frame_done); both 0 after reset.
REQ-032 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 NUM_LANES=4, beat 0x44332211, out_ready=1 -> out_pixel 0x11,0x22,0x33,0x44 in cycles N+1..N+4, out_sof=1 on 0x11.
REQ-034 Continuous in_valid, out_ready=1 -> in_ready high every 4th cycle, out_valid never drops after first beat.
REQ-035 out_ready held 0 for 5 cycles mid-beat -> out_pixel/col stable; stall_count=5 with HOG_INGRESS_STATS_EN.
REQ-036 Full 640x480 frame streamed -> out_eol at col 639 each row, out_eof once at (639,479), frame_done 1 cycle later, next pixel col=0,row=0 with out_sof.
REQ-037 rst asserted at col=322,row=7 -> next cycle out_valid=0, col=0,row=0; next beat tagged out_sof.
REQ-038 NUM_LANES=1, IMAGE_WIDTH=4, IMAGE_HEIGHT=2 -> 8 pixels, eol at pixels 3 and 7, eof at pixel 7, frame_count=1.

Source files
------------

// File: rtl/hog_pixel_ingress.sv
// Beat-to-pixel serializer at the front of the HOG pipeline. It tags each pixel with
// its column, row and frame boundaries. Define HOG_INGRESS_STATS_EN to add the frame and stall counters.
module hog_pixel_ingress #(
  parameter int DATA_WIDTH   = 8,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int NUM_LANES    = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*NUM_LANES-1:0]   in_pixels,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH-1:0]             out_pixel,
  output logic                              out_sof,
  output logic                              out_eol,
  output logic                              out_eof,
  output logic [$clog2(IMAGE_WIDTH)-1:0]    col,
  output logic [$clog2(IMAGE_HEIGHT)-1:0]   row,
  output logic                              frame_done
`ifdef HOG_INGRESS_STATS_EN
  ,
  output logic [15:0]                       frame_count,
  output logic [15:0]                       stall_count
`endif
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(IMAGE_HEIGHT - 1);

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                         state, state_next;
  logic [LW-1:0]                  idx, idx_next;
  logic [DATA_WIDTH*NUM_LANES-1:0] beat;
  logic                           capture;
  logic                           last_lane;
  logic                           out_hs;

  assign last_lane = (idx == LAST_LANE);
  assign out_valid = (state == DRAIN);
  assign out_hs    = out_valid && out_ready;

  // The next beat is taken in the same cycle the last lane leaves, so beats
  // chain back-to-back without a bubble.
  assign in_ready = !rst && ((state == EMPTY) || (last_lane && out_ready));

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    capture    = 1'b0;
    case (state)
      EMPTY: begin
        if (in_valid && in_ready) begin
          capture    = 1'b1;
          idx_next   = '0;
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_lane) begin
            idx_next = '0;
            if (in_valid) capture = 1'b1;
            else          state_next = EMPTY;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_pixel = '0;
    for (int k = 0; k < NUM_LANES; k++)
      if (idx == LW'(k)) out_pixel = beat[k*DATA_WIDTH +: DATA_WIDTH];
  end

  assign out_sof = out_valid && (col == '0) && (row == '0);
  assign out_eol = out_valid && (col == LAST_COL);
  assign out_eof = out_eol && (row == LAST_ROW);

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values. The held beat is also cleared on reset, so a beat
  // discarded by reset never reappears on out_pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      idx        <= '0;
      beat       <= '0;
      col        <= '0;
      row        <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      frame_done <= out_hs && out_eof;
      if (capture) beat <= in_pixels;
      if (out_hs) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

`ifdef HOG_INGRESS_STATS_EN
  // The stall count covers one frame. It restarts when the frame_done pulse is seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_count <= '0;
      stall_count <= '0;
    end else if (frame_done) begin
      frame_count <= frame_count + 16'd1;
      stall_count <= '0;
    end else if (out_valid && !out_ready && stall_count != 16'hFFFF) begin
      stall_count <= stall_count + 16'd1;
    end
  end
`endif

endmodule
